// File: rtl/cmd_seq_pkg.sv
// Shared op/state encodings, default magnitudes and timing for the line-follower command sequencer.
package cmd_seq_pkg;

  typedef enum logic [1:0] {
    OP_STOP  = 2'b00,
    OP_LEFT  = 2'b01,
    OP_RIGHT = 2'b10,
    OP_REV   = 2'b11
  } op_t;

  // State codes are kept as plain constants so older blocks can share the same encoding.
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_FOLLOW = 3'd1;
  localparam state_t S_VEER   = 3'd2;
  localparam state_t S_REV1   = 3'd3;
  localparam state_t S_REV2   = 3'd4;
  localparam state_t S_SEARCH = 3'd5;
  localparam state_t S_BUMP   = 3'd6;

  localparam logic [15:0] VEER_MAG_DEF = 16'h0340;
  localparam logic [15:0] REV1_MAG_DEF = 16'h01E0;
  localparam logic [15:0] REV2_MAG_DEF = 16'h0380;
  localparam int          REV1_CYC_DEF = 22 << 16;
  localparam int          REV2_CYC_DEF = 31 << 21;
  localparam int          DBNC_CYC_DEF = 1 << 22;
  localparam int          BUZZ_DIV_DEF = 12500;

  // One shared timer serves both reverse phases and the debounce, so it is sized for the longest.
  function automatic int tmr_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cmd_seq_fifo.sv
// DEPTH x W synchronous command FIFO with full/empty flags and asynchronous active-low reset.
module cmd_seq_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two; push+pop together leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cmd_seq_proc.sv
// Line-follower command sequencer: queues UART command words and plays their 2-bit ops on line loss.
// Build option CMD_SEQ_PROC_BUZZ_TONE_EN: buzz becomes a BUZZ_DIV-cycle square tone instead of a steady level.
module cmd_seq_proc
  import cmd_seq_pkg::*;
#(
  parameter int          CMD_W    = 16,
  parameter int          DEPTH    = 4,
  parameter int          ERR_W    = 16,
  parameter logic [15:0] VEER_MAG = VEER_MAG_DEF,
  parameter logic [15:0] REV1_MAG = REV1_MAG_DEF,
  parameter logic [15:0] REV2_MAG = REV2_MAG_DEF,
  parameter int          REV1_CYC = REV1_CYC_DEF,
  parameter int          REV2_CYC = REV2_CYC_DEF,
  parameter int          DBNC_CYC = DBNC_CYC_DEF,
  parameter int          BUZZ_DIV = BUZZ_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CMD_W-1:0] cmd,
  input  logic             cmd_rdy,
  output logic             clr_cmd_rdy,
  input  logic             line_present,
  input  logic             BMPL_n,
  input  logic             BMPR_n,
  output logic             go,
  output logic [ERR_W-1:0] err_opn_lp,
  output logic             buzz,
  output logic             busy,
  output logic             cmd_done
);

  localparam int OPC_W = $clog2(CMD_W / 2 + 1);
  localparam int TMR_W = tmr_width(REV1_CYC, REV2_CYC, DBNC_CYC);

  localparam logic [OPC_W-1:0] OPS      = OPC_W'(CMD_W / 2);
  localparam logic [TMR_W-1:0] REV1_END = TMR_W'(REV1_CYC - 1);
  localparam logic [TMR_W-1:0] REV2_END = TMR_W'(REV2_CYC - 1);
  localparam logic [TMR_W-1:0] DBNC_END = TMR_W'(DBNC_CYC - 1);

  localparam logic [ERR_W-1:0] VEER_E = ERR_W'($signed(VEER_MAG));
  localparam logic [ERR_W-1:0] REV1_E = ERR_W'($signed(REV1_MAG));
  localparam logic [ERR_W-1:0] REV2_E = ERR_W'($signed(REV2_MAG));

  state_t           state;
  state_t           saved;
  logic [CMD_W-1:0] sr;
  logic [OPC_W-1:0] op_cnt;
  logic [TMR_W-1:0] tmr;
  logic [TMR_W-1:0] tmr_inc;
  logic             last_dir;
  logic [CMD_W-1:0] fifo_dout;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             bump;
  op_t              op;

  assign bump    = !BMPL_n || !BMPR_n;
  assign pop     = (state == S_IDLE) && line_present && !empty;
  assign push    = rst_n && cmd_rdy && (!full || pop);
  assign op      = (op_cnt == OPS) ? OP_STOP : op_t'(sr[1:0]);
  assign tmr_inc = (tmr == '1) ? tmr : tmr + 1'b1;

  assign clr_cmd_rdy = push;

  cmd_seq_fifo #(
    .W    (CMD_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .din  (cmd),
    .dout (fifo_dout),
    .full (full),
    .empty(empty)
  );

  // A bumper hit pre-empts every other transition; the interrupted state resumes with a fresh timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      saved    <= S_IDLE;
      sr       <= '0;
      op_cnt   <= '0;
      tmr      <= '0;
      last_dir <= 1'b0;
      cmd_done <= 1'b0;
    end else begin
      cmd_done <= 1'b0;
      if (bump && state != S_IDLE && state != S_BUMP) begin
        saved <= state;
        state <= S_BUMP;
        tmr   <= '0;
      end else begin
        case (state)
          S_IDLE: if (pop) begin
            sr     <= fifo_dout;
            op_cnt <= '0;
            state  <= S_FOLLOW;
          end
          S_FOLLOW: if (!line_present) begin
            tmr <= '0;
            case (op)
              OP_STOP: begin
                cmd_done <= 1'b1;
                state    <= S_IDLE;
              end
              OP_LEFT, OP_RIGHT: state <= S_VEER;
              default:           state <= S_REV1;
            endcase
          end
          S_VEER: if (line_present) begin
            last_dir <= (op == OP_RIGHT);
            sr       <= {2'b00, sr[CMD_W-1:2]};
            op_cnt   <= op_cnt + 1'b1;
            state    <= S_FOLLOW;
          end
          S_REV1: if (tmr == REV1_END) begin
            tmr   <= '0;
            state <= S_REV2;
          end else tmr <= tmr_inc;
          S_REV2: if (tmr == REV2_END) begin
            tmr   <= '0;
            state <= S_SEARCH;
          end else tmr <= tmr_inc;
          S_SEARCH: if (line_present) begin
            sr     <= {2'b00, sr[CMD_W-1:2]};
            op_cnt <= op_cnt + 1'b1;
            state  <= S_FOLLOW;
          end
          S_BUMP: if (bump) tmr <= '0;
            else if (tmr == DBNC_END) begin
              tmr   <= '0;
              state <= saved;
            end else tmr <= tmr_inc;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign go   = (state != S_IDLE) && (state != S_BUMP);
  assign busy = (state != S_IDLE);

  always_comb begin
    err_opn_lp = '0;
    case (state)
      S_VEER:  err_opn_lp = (op == OP_RIGHT) ? -VEER_E : VEER_E;
      S_REV1:  err_opn_lp = last_dir ? -REV1_E : REV1_E;
      S_REV2:  err_opn_lp = last_dir ? REV2_E : -REV2_E;
      default: err_opn_lp = '0;
    endcase
  end

`ifdef CMD_SEQ_PROC_BUZZ_TONE_EN
  localparam int DIV_W = $clog2(BUZZ_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_END = DIV_W'(BUZZ_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tone;

  // Tone phase is re-armed high whenever we are outside BUMP so every bump starts with the piezo on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      tone    <= 1'b1;
    end else if (state != S_BUMP) begin
      div_cnt <= '0;
      tone    <= 1'b1;
    end else if (div_cnt == DIV_END) begin
      div_cnt <= '0;
      tone    <= ~tone;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign buzz = (state == S_BUMP) && tone;
`else
  assign buzz = (state == S_BUMP);
`endif

endmodule
